lc_prbs_link_checker: RTL and testbench

Synthesisable, parametrised link exerciser for the 8b/10b datapath. It generates a PRBS word stream on LANES byte lanes for the encoder input and checks the decoder output with a self-synchronising PRBS checker. It also runs a lock state machine and keeps a saturating bit-error counter. It sits between the system and the encoder_8b10b/decoder_10b8b pair, and is used for on-chip loopback and bring-up.

---
 rtl/lc_prbs_link_checker_pkg.sv | 26 ++
 rtl/lc_prbs_link_checker_gen.sv | 43 ++++
 rtl/lc_prbs_link_checker.sv | 169 ++++++++++++++++
 tb/tb_lc_prbs_link_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc_prbs_link_checker_pkg.sv
// Shared definitions for the PRBS link checker: lane width, checker states
// and the feedback tap lookup used by both generator and checker.
package lc_pkg;

   localparam int LANE_W = 8;

   typedef enum logic [1:0] {
      PRIME,
      SEARCH,
      LOCKED
   } lc_state_t;

   // Second tap M for the supported polynomial orders x^N + x^M + 1.
   function automatic int prbs_tap(input int n);
      int m;
      case (n)
         7:       m = 6;
         15:      m = 14;
         23:      m = 18;
         31:      m = 28;
         default: m = n - 1;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lc_prbs_link_checker_gen.sv
// PRBS word generator: Fibonacci LFSR advanced LANES*8 bit steps per enabled cycle,
// bit k of the word being the k-th bit produced.
module lc_prbs_gen
   import lc_pkg::*;
#(
   parameter int LANES  = 1,
   parameter int PRBS_N = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   output logic [LANES*LANE_W-1:0]   word
);

   localparam int W = LANES * LANE_W;
   localparam int M = prbs_tap(PRBS_N);

   logic [PRBS_N-1:0] lfsr;
   logic [PRBS_N-1:0] lfsr_next;

   always_comb begin
      logic [PRBS_N-1:0] s;
      logic              b;
      s    = lfsr;
      b    = 1'b0;
      word = '0;
      for (int k = 0; k < W; k++) begin
         b       = s[PRBS_N-1] ^ s[M-1];
         s       = {s[PRBS_N-2:0], b};
         word[k] = b;
      end
      lfsr_next = s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= '1;
      end else if (en) begin
         lfsr <= lfsr_next;
      end
   end

endmodule

// File: rtl/lc_prbs_link_checker.sv
// Link exerciser: PRBS word generator towards the encoder and a self-synchronising
// PRBS checker with lock FSM and saturating bit-error counter on the decoder side.
module lc_prbs_link_checker
   import lc_pkg::*;
#(
   parameter int LANES      = 1,
   parameter int PRBS_N     = 7,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_ERR = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   err_inject,
   output logic [LANES*8-1:0]     tx_data,
   output logic                   tx_valid,
   input  logic [LANES*8-1:0]     rx_data,
   input  logic                   rx_valid,
   input  logic                   err_clr,
   output logic                   locked,
   output logic                   err_pulse,
   output logic [ERR_CNT_W-1:0]   err_count
);

   localparam int W      = LANES * LANE_W;
   localparam int M      = prbs_tap(PRBS_N);
   localparam int CNT_W  = $clog2(W + 1);
   localparam int FILL_W = $clog2(PRBS_N + W + 1);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_ERR + 1);
   localparam int SUM_W  = ((ERR_CNT_W > CNT_W) ? ERR_CNT_W : CNT_W) + 1;

   logic [W-1:0]         gen_word;
   logic [PRBS_N-1:0]    hist;
   logic [PRBS_N-1:0]    hist_next;
   logic [CNT_W-1:0]     mism_cnt;
   logic                 zero_word;
   logic                 bad_word;
   lc_state_t            state;
   lc_state_t            state_next;
   logic [FILL_W-1:0]    fill_cnt;
   logic [FILL_W-1:0]    fill_next;
   logic [FILL_W-1:0]    fill_sum;
   logic [GOOD_W-1:0]    good_cnt;
   logic [GOOD_W-1:0]    good_next;
   logic [BAD_W-1:0]     bad_cnt;
   logic [BAD_W-1:0]     bad_next;
   logic [SUM_W-1:0]     err_sum;
   logic [ERR_CNT_W-1:0] err_sat;

   lc_prbs_gen #(
      .LANES  (LANES),
      .PRBS_N (PRBS_N)
   ) u_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .word (gen_word)
   );

   // Injected errors touch only the outgoing word, never the LFSR sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data  <= '0;
         tx_valid <= 1'b0;
      end else begin
         tx_valid <= en;
         if (en) begin
            tx_data <= gen_word ^ W'(err_inject);
         end
      end
   end

   always_comb begin
      logic p;
      hist_next = hist;
      mism_cnt  = '0;
      p         = 1'b0;
      for (int k = 0; k < W; k++) begin
         p         = hist_next[PRBS_N-1] ^ hist_next[M-1];
         mism_cnt  = mism_cnt + CNT_W'(rx_data[k] ^ p);
         hist_next = {hist_next[PRBS_N-2:0], rx_data[k]};
      end
      zero_word = (rx_data == '0) && (hist == '0);
      bad_word  = zero_word || (mism_cnt != '0);
   end

   assign fill_sum = fill_cnt + FILL_W'(W);

   always_comb begin
      state_next = state;
      fill_next  = fill_cnt;
      good_next  = good_cnt;
      bad_next   = bad_cnt;
      if (rx_valid) begin
         case (state)
            PRIME: begin
               fill_next = fill_sum;
               if (fill_sum >= FILL_W'(PRBS_N)) begin
                  state_next = SEARCH;
               end
            end
            SEARCH: begin
               if (bad_word) begin
                  good_next = '0;
               end else begin
                  good_next = good_cnt + GOOD_W'(1);
                  if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                     state_next = LOCKED;
                     bad_next   = '0;
                  end
               end
            end
            LOCKED: begin
               if (bad_word) begin
                  bad_next = bad_cnt + BAD_W'(1);
                  if (bad_cnt == BAD_W'(UNLOCK_ERR - 1)) begin
                     state_next = SEARCH;
                     good_next  = '0;
                  end
               end else begin
                  bad_next = '0;
               end
            end
            default: state_next = PRIME;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= PRIME;
         hist     <= '0;
         fill_cnt <= '0;
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         state    <= state_next;
         fill_cnt <= fill_next;
         good_cnt <= good_next;
         bad_cnt  <= bad_next;
         if (rx_valid) begin
            hist <= hist_next;
         end
      end
   end

   assign err_sum = SUM_W'(err_count) + SUM_W'(mism_cnt);
   assign err_sat = (err_sum > SUM_W'({ERR_CNT_W{1'b1}})) ? '1 : err_sum[ERR_CNT_W-1:0];

   // A clear request overrides a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         if (err_clr) begin
            err_count <= '0;
         end else if (rx_valid && (state == LOCKED)) begin
            err_count <= err_sat;
         end
         locked    <= (state_next == LOCKED);
         err_pulse <= rx_valid && (state == LOCKED) && (mism_cnt != '0);
      end
   end

endmodule

// File: tb/tb_lc_prbs_link_checker.sv
// Bench for lc_prbs_link_checker: bit-stream reference model driven alongside the DUT,
// loopback and fault scenarios with randomised gaps.
module tb_lc_prbs_link_checker;

   localparam int N       = 7;
   localparam int M       = 6;
   localparam int W       = 8;
   localparam int LOCK    = 16;
   localparam int UNL     = 4;
   localparam int ECW     = 4;
   localparam int ERR_MAX = (1 << ECW) - 1;
   localparam int ST_PRIME  = 0;
   localparam int ST_SEARCH = 1;
   localparam int ST_LOCKED = 2;
   localparam bit [30:0] LMASK = 31'((1 << N) - 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          err_inject;
   logic [W-1:0]  tx_data;
   logic          tx_valid;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic          err_clr;
   logic          locked;
   logic          err_pulse;
   logic [ECW-1:0] err_count;

   int total = 0;
   int bad   = 0;

   bit [30:0]  m_lfsr;
   logic [7:0] m_tx;
   logic       m_txv;
   bit         m_bits[$];
   int         m_st, m_fill, m_good, m_bad, m_err, m_last_mism;
   logic       m_locked, m_pulse;

   wire [14:0] dut_vec = {tx_data, tx_valid, locked, err_pulse, err_count};

   lc_prbs_link_checker #(
      .LANES      (1),
      .PRBS_N     (N),
      .LOCK_CNT   (LOCK),
      .UNLOCK_ERR (UNL),
      .ERR_CNT_W  (ECW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .err_inject (err_inject),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .err_clr    (err_clr),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   function automatic bit hbit(input int idx);
      if (idx < 0) return 1'b0;
      return m_bits[idx];
   endfunction

   function automatic logic [14:0] exp_vec();
      return {m_tx, m_txv, m_locked, m_pulse, 4'(m_err)};
   endfunction

   // Drive one cycle of inputs, advance the reference model, land 1 time unit after the edge.
   task automatic tick(input logic i_en, input logic i_inj, input logic [7:0] i_rxd,
                       input logic i_rxv, input logic i_clr, input logic i_rst);
      int mism;
      bit zg, p, b, bw;
      logic [7:0] w;
      en = i_en; err_inject = i_inj; rx_data = i_rxd; rx_valid = i_rxv;
      err_clr = i_clr; rst = i_rst;
      mism = 0;
      w = 8'h00;
      if (i_rst) begin
         m_lfsr = LMASK; m_tx = 8'h00; m_txv = 1'b0; m_bits.delete();
         m_st = ST_PRIME; m_fill = 0; m_good = 0; m_bad = 0; m_err = 0;
         m_locked = 1'b0; m_pulse = 1'b0;
      end else begin
         if (i_en) begin
            for (int k = 0; k < W; k++) begin
               b = m_lfsr[N-1] ^ m_lfsr[M-1];
               m_lfsr = ((m_lfsr << 1) | 31'(b)) & LMASK;
               w[k] = b;
            end
            m_tx = w ^ {7'b0, i_inj};
         end
         m_txv = i_en;
         m_pulse = 1'b0;
         if (i_rxv) begin
            zg = (i_rxd == 8'h00);
            for (int j = 1; j <= N; j++) if (hbit(m_bits.size() - j)) zg = 1'b0;
            for (int k = 0; k < W; k++) begin
               p = hbit(m_bits.size() - N) ^ hbit(m_bits.size() - M);
               if (i_rxd[k] != p) mism++;
               m_bits.push_back(i_rxd[k]);
            end
            bw = zg || (mism > 0);
            if (m_st == ST_PRIME) begin
               m_fill += W;
               if (m_fill >= N) m_st = ST_SEARCH;
            end else if (m_st == ST_SEARCH) begin
               if (bw) m_good = 0;
               else begin
                  m_good++;
                  if (m_good == LOCK) begin m_st = ST_LOCKED; m_bad = 0; end
               end
            end else begin
               m_err = (m_err + mism > ERR_MAX) ? ERR_MAX : m_err + mism;
               m_pulse = (mism > 0);
               if (bw) begin
                  m_bad++;
                  if (m_bad == UNL) begin m_st = ST_SEARCH; m_good = 0; end
               end else m_bad = 0;
            end
         end
         if (i_clr) m_err = 0;
         m_locked = (m_st == ST_LOCKED);
      end
      m_last_mism = mism;
      @(posedge clk);
      #1;
   endtask

   task automatic relock();
      int c = 0;
      while (!m_locked && c < 200) begin
         tick(1'b1, 1'b0, m_tx, m_txv, 1'b0, 1'b0);
         c++;
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", locked); end
      total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
      total++; if (err_count !== 4'h0) begin bad++; $display("FAIL reset_err_count got=%h want=0", err_count); end
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      total++; if (tx_data !== 8'h40) begin bad++; $display("FAIL first_word got=%h want=40", tx_data); end
      total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%b want=1", tx_valid); end
   endtask

   task automatic test_loopback();
      int words = 0;
      int c = 0;
      while (words < 1000 && c < 3000) begin
         logic e, v;
         logic [7:0] d;
         e = ($urandom_range(0, 9) != 0);
         v = m_txv;
         d = v ? m_tx : 8'($urandom);
         tick(e, 1'b0, d, v, 1'b0, 1'b0);
         c++;
         if (v) words++;
         total++;
         if (dut_vec !== exp_vec()) begin
            bad++; $display("FAIL loopback_cycle %0d got=%h want=%h", c, dut_vec, exp_vec());
         end
         if (v && words == 16) begin
            total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_early got=%b want=0", locked); end
         end
         if (v && words == 17) begin
            total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_at_17 got=%b want=1", locked); end
         end
      end
      total++; if (words != 1000) begin bad++; $display("FAIL loopback_budget words=%0d want=1000", words); end
      total++; if (err_count !== 4'h0) begin bad++; $display("FAIL loopback_err_count got=%h want=0", err_count); end
   endtask

   task automatic test_err_inject();
      int e0, pulses;
      e0 = m_err;
      pulses = 0;
      tick(1'b1, 1'b1, m_tx, m_txv, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, 1'b0, m_tx, m_txv, 1'b0, 1'b0);
         if (err_pulse === 1'b1) pulses++;
         total++; if (locked !== 1'b1) begin bad++; $display("FAIL inject_locked cycle %0d got=%b want=1", i, locked); end
         total++;
         if (dut_vec !== exp_vec()) begin bad++; $display("FAIL inject_cycle %0d got=%h want=%h", i, dut_vec, exp_vec()); end
      end
      total++;
      if (err_count !== 4'((e0 + 3 > ERR_MAX) ? ERR_MAX : e0 + 3)) begin
         bad++; $display("FAIL inject_err_count got=%0d want=%0d", err_count, e0 + 3);
      end
      total++; if (pulses < 1 || pulses > 2) begin bad++; $display("FAIL inject_pulses got=%0d want=1..2", pulses); end
   endtask

   task automatic test_stuck_zero();
      int e0, fall, first_mism;
      bit relocked;
      e0 = m_err; fall = -1; first_mism = 0; relocked = 1'b0;
      for (int i = 1; i <= 24; i++) begin
         tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         if (i == 1) first_mism = m_last_mism;
         if (locked === 1'b0 && fall < 0) fall = i;
         if (fall > 0 && locked !== 1'b0) relocked = 1'b1;
         total++;
         if (dut_vec !== exp_vec()) begin bad++; $display("FAIL stuck_cycle %0d got=%h want=%h", i, dut_vec, exp_vec()); end
      end
      total++;
      if (!(fall == 4 || (first_mism == 0 && fall == 5))) begin
         bad++; $display("FAIL stuck_unlock_word got=%0d want=4", fall);
      end
      total++; if (relocked) begin bad++; $display("FAIL stuck_relock got=1 want=0"); end
      total++;
      if (err_count !== 4'((e0 + first_mism > ERR_MAX) ? ERR_MAX : e0 + first_mism) || first_mism > 8) begin
         bad++; $display("FAIL stuck_err_count got=%0d want=%0d", err_count, e0 + first_mism);
      end
   endtask

   task automatic test_saturate();
      relock();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_a got=%b want=1", locked); end
      for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      total++; if (err_count !== 4'hF) begin bad++; $display("FAIL saturate got=%h want=f", err_count); end
      relock();
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL relock_b got=%b want=1", locked); end
      tick(1'b1, 1'b0, m_tx ^ 8'h01, 1'b1, 1'b1, 1'b0);
      total++; if (err_count !== 4'h0) begin bad++; $display("FAIL clr_wins got=%h want=0", err_count); end
      total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL clr_word_pulse got=%b want=1", err_pulse); end
      tick(1'b1, 1'b0, m_tx, m_txv, 1'b0, 1'b0);
      total++; if (err_count !== 4'h0) begin bad++; $display("FAIL clr_hold got=%h want=0", err_count); end
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 1'b0, m_tx ^ 8'h07, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, m_tx, m_txv, 1'b0, 1'b0);
      total++; if (err_count !== 4'd5) begin bad++; $display("FAIL pre_reset_count got=%0d want=5", err_count); end
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL pre_reset_locked got=%b want=1", locked); end
      tick(1'b1, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL mid_reset_locked got=%b want=0", locked); end
      total++; if (err_count !== 4'h0) begin bad++; $display("FAIL mid_reset_count got=%h want=0", err_count); end
      total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_reset_tx got=%h want=00", tx_data); end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", tx_valid); end
      tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      total++; if (tx_data !== 8'h40) begin bad++; $display("FAIL restart_word got=%h want=40", tx_data); end
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, m_tx, m_txv, 1'b0, 1'b0);
         total++;
         if (dut_vec !== exp_vec()) begin bad++; $display("FAIL restart_cycle %0d got=%h want=%h", i, dut_vec, exp_vec()); end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; err_inject = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; err_clr = 1'b0;
      test_reset();
      test_loopback();
      test_err_inject();
      test_stuck_zero();
      test_saturate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

endmodule
